// File: rtl/kalman_step_sequencer_if.sv
// kalman_step_sequencer_if
// Bundles every non-clock signal of the Kalman step sequencer.
//   i_* : driven by the environment (upstream source, filter core, downstream sink)
//   o_* : driven by the sequencer
// Groups:
//   sample in : i_in_valid / o_in_ready / i_u0 / i_y0 / i_y1
//   core side : o_core_clk_en / o_core_u0 / o_core_y0 / o_core_y1 / i_core_state0..2
//   result out: o_out_valid / i_out_ready / o_state0..3
//   status    : i_clear / o_step_count / o_busy / o_drop_count
// Modports: slave = sequencer, master = environment.
interface kalman_step_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) ();
  logic              i_clear;
  logic              i_in_valid;
  logic              o_in_ready;
  logic [DATA_W-1:0] i_u0;
  logic [DATA_W-1:0] i_y0;
  logic [DATA_W-1:0] i_y1;
  logic              o_core_clk_en;
  logic [DATA_W-1:0] o_core_u0;
  logic [DATA_W-1:0] o_core_y0;
  logic [DATA_W-1:0] o_core_y1;
  logic [DATA_W-1:0] i_core_state0;
  logic [DATA_W-1:0] i_core_state1;
  logic [DATA_W-1:0] i_core_state2;
  logic              o_out_valid;
  logic              i_out_ready;
  logic [DATA_W-1:0] o_state0;
  logic [DATA_W-1:0] o_state1;
  logic [DATA_W-1:0] o_state2;
  logic [DATA_W-1:0] o_state3;
  logic [CNT_W-1:0]  o_step_count;
  logic              o_busy;
  logic [7:0]        o_drop_count;

  modport slave (
    input  i_clear, i_in_valid, i_u0, i_y0, i_y1,
    input  i_core_state0, i_core_state1, i_core_state2, i_out_ready,
    output o_in_ready, o_core_clk_en, o_core_u0, o_core_y0, o_core_y1,
    output o_out_valid, o_state0, o_state1, o_state2, o_state3,
    output o_step_count, o_busy, o_drop_count
  );

  modport master (
    output i_clear, i_in_valid, i_u0, i_y0, i_y1,
    output i_core_state0, i_core_state1, i_core_state2, i_out_ready,
    input  o_in_ready, o_core_clk_en, o_core_u0, o_core_y0, o_core_y1,
    input  o_out_valid, o_state0, o_state1, o_state2, o_state3,
    input  o_step_count, o_busy, o_drop_count
  );
endinterface

// File: rtl/kalman_step_sequencer.sv
// kalman_step_sequencer
// Feeds one measurement sample at a time to a 3-state Kalman filter core:
// latches the sample onto the core inputs, fires a single clk_en step, waits
// the core's fixed latency, captures State0..2 and offers them downstream.
// Ports:
//   i_clk : system clock
//   i_rst : asynchronous active-high reset
//   bus   : kalman_step_sequencer_if.slave (sample in, core side, result out, status)
//
// state | meaning
// IDLE  | no sample held, ready to accept
// STEP  | core_clk_en high for exactly one cycle
// WAIT  | counting CORE_LATENCY cycles for the core outputs to settle
// DONE  | result offered on out_valid until out_ready
module kalman_step_sequencer #(
  parameter int DATA_W       = 16,
  parameter int CORE_LATENCY = 4,
  parameter int CNT_W        = 16
) (
  input logic                    i_clk,
  input logic                    i_rst,
  kalman_step_sequencer_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [7:0] LAST_WAIT = 8'(CORE_LATENCY - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_wait_cnt;
  logic              r_core_clk_en;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_core_u0;
  logic [DATA_W-1:0] r_core_y0;
  logic [DATA_W-1:0] r_core_y1;
  logic [DATA_W-1:0] r_state0;
  logic [DATA_W-1:0] r_state1;
  logic [DATA_W-1:0] r_state2;
  logic [CNT_W-1:0]  r_step_count;
  logic [7:0]        r_drop_count;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_capture;

  // clear wins over a sample offered in the same cycle: it is not taken, and
  // a capture due in that cycle is abandoned.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && bus.i_out_ready);
    w_accept    = bus.i_in_valid && w_in_ready && !bus.i_clear;
    w_capture   = (r_state == S_WAIT) && (r_wait_cnt == LAST_WAIT) && !bus.i_clear;
    if (bus.i_clear) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) w_state_nxt = S_STEP;
        S_STEP: w_state_nxt = S_WAIT;
        S_WAIT: if (w_capture) w_state_nxt = S_DONE;
        S_DONE: begin
          if (w_accept) w_state_nxt = S_STEP;
          else if (bus.i_out_ready) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_core_clk_en <= 1'b0;
      r_out_valid   <= 1'b0;
      r_wait_cnt    <= '0;
      r_core_u0     <= '0;
      r_core_y0     <= '0;
      r_core_y1     <= '0;
      r_state0      <= '0;
      r_state1      <= '0;
      r_state2      <= '0;
      r_step_count  <= '0;
      r_drop_count  <= '0;
    end else begin
      // Decoded from the next state so both strobes are glitch-free registers.
      r_core_clk_en <= (w_state_nxt == S_STEP);
      r_out_valid   <= (w_state_nxt == S_DONE);

      if (w_accept) begin
        r_core_u0 <= bus.i_u0;
        r_core_y0 <= bus.i_y0;
        r_core_y1 <= bus.i_y1;
      end

      if (bus.i_clear || (r_state == S_STEP)) r_wait_cnt <= '0;
      else if (r_state == S_WAIT)             r_wait_cnt <= r_wait_cnt + 8'd1;

      if (w_capture) begin
        r_state0 <= bus.i_core_state0;
        r_state1 <= bus.i_core_state1;
        r_state2 <= bus.i_core_state2;
        if (r_step_count != {CNT_W{1'b1}}) r_step_count <= r_step_count + CNT_W'(1);
      end

      if (bus.i_in_valid && !w_in_ready && (r_drop_count != 8'hFF))
        r_drop_count <= r_drop_count + 8'd1;
    end
  end

  assign bus.o_in_ready    = w_in_ready;
  assign bus.o_core_clk_en = r_core_clk_en;
  assign bus.o_core_u0     = r_core_u0;
  assign bus.o_core_y0     = r_core_y0;
  assign bus.o_core_y1     = r_core_y1;
  assign bus.o_out_valid   = r_out_valid;
  assign bus.o_state0      = r_state0;
  assign bus.o_state1      = r_state1;
  assign bus.o_state2      = r_state2;
  assign bus.o_state3      = '0;
  assign bus.o_step_count  = r_step_count;
  assign bus.o_busy        = (r_state == S_STEP) || (r_state == S_WAIT);
  assign bus.o_drop_count  = r_drop_count;
endmodule

// File: tb/tb_kalman_step_sequencer.sv
module tb_kalman_step_sequencer;
  localparam int DATA_W    = 16;
  localparam int LAT       = 4;
  localparam int CNT_W     = 4;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;
  localparam int STEP_SPAN = LAT + 2;
  localparam int NRAND     = 12;

  typedef struct packed { logic [DATA_W-1:0] s0, s1, s2; } result_t;
  typedef struct packed { logic [DATA_W-1:0] u0, y0, y1; } sample_t;

  logic              clk       = 1'b0;
  logic              rst       = 1'b1;
  logic              clear     = 1'b0;
  logic              in_valid  = 1'b0;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] u0 = '0, y0 = '0, y1 = '0;
  logic [DATA_W-1:0] core_s0 = '0, core_s1 = '0, core_s2 = '0;

  int checks = 0;
  int errors = 0;
  int exp_steps = 0;
  int exp_drop  = 0;
  bit      use_override  = 1'b0;
  result_t core_override = '0;

  always #5 clk = ~clk;

  kalman_step_sequencer_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  assign bus.i_clear       = clear;
  assign bus.i_in_valid    = in_valid;
  assign bus.i_u0          = u0;
  assign bus.i_y0          = y0;
  assign bus.i_y1          = y1;
  assign bus.i_out_ready   = out_ready;
  assign bus.i_core_state0 = core_s0;
  assign bus.i_core_state1 = core_s1;
  assign bus.i_core_state2 = core_s2;

  kalman_step_sequencer #(.DATA_W(DATA_W), .CORE_LATENCY(LAT), .CNT_W(CNT_W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // Stand-in for the filter core: a deterministic function of the inputs it stepped on.
  function automatic result_t core_fn(input sample_t s);
    result_t r;
    r.s0 = s.u0 + s.y0;
    r.s1 = s.y0 ^ s.y1;
    r.s2 = s.y1 - s.u0;
    return r;
  endfunction

  function automatic sample_t rand_sample();
    sample_t s;
    s.u0 = 16'($urandom);
    s.y0 = 16'($urandom);
    s.y1 = 16'($urandom);
    return s;
  endfunction

  function automatic logic [CNT_W-1:0] sat_steps(input int n);
    return CNT_W'((n > CNT_MAX) ? CNT_MAX : n);
  endfunction

  // Core model: outputs change LAT cycles after the cycle in which clk_en was high.
  int      core_cd = 0;
  result_t core_pend;
  always @(posedge clk) begin
    if (core_cd > 0) begin
      core_cd = core_cd - 1;
      if (core_cd == 0) begin
        core_s0 <= core_pend.s0;
        core_s1 <= core_pend.s1;
        core_s2 <= core_pend.s2;
      end
    end
    if (bus.o_core_clk_en === 1'b1) begin
      core_pend = use_override ? core_override
                               : core_fn(sample_t'({bus.o_core_u0, bus.o_core_y0, bus.o_core_y1}));
      core_cd = LAT - 1;
    end
  end

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({bus.o_core_u0, bus.o_core_y0, bus.o_core_y1, bus.o_state0, bus.o_state1,
         bus.o_state2, bus.o_state3} !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", {bus.o_core_u0, bus.o_core_y0,
               bus.o_core_y1, bus.o_state0, bus.o_state1, bus.o_state2, bus.o_state3});
    end
    checks++;
    if ({bus.o_step_count, bus.o_drop_count, bus.o_core_clk_en, bus.o_out_valid, bus.o_busy} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: got %h expected 0",
               {bus.o_step_count, bus.o_drop_count, bus.o_core_clk_en, bus.o_out_valid, bus.o_busy});
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.o_in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.o_in_ready);
    end
    exp_steps = 0; exp_drop = 0;
  endtask

  task automatic test_single_step();
    result_t exp_r;
    int seen, extra_pulses;
    exp_r.s0 = 16'h1111; exp_r.s1 = 16'h2222; exp_r.s2 = 16'h3333;
    use_override = 1'b1; core_override = exp_r;
    out_ready = 1'b1;
    @(negedge clk);
    u0 = 16'h0010; y0 = 16'h0100; y1 = 16'h0200; in_valid = 1'b1;
    #1;
    checks++;
    if (bus.o_in_ready !== 1'b1) begin
      errors++; $display("FAIL single_accept: in_ready got %b expected 1", bus.o_in_ready);
    end
    @(negedge clk); in_valid = 1'b0; #1;
    checks++;
    if ({bus.o_core_clk_en, bus.o_busy} !== 2'b11) begin
      errors++; $display("FAIL single_clk_en: {clk_en,busy} got %b expected 11", {bus.o_core_clk_en, bus.o_busy});
    end
    checks++;
    if ({bus.o_core_u0, bus.o_core_y0, bus.o_core_y1} !== 48'h0010_0100_0200) begin
      errors++; $display("FAIL single_core_in: got %h expected 001001000200",
                         {bus.o_core_u0, bus.o_core_y0, bus.o_core_y1});
    end
    seen = 0; extra_pulses = 0;
    for (int c = 2; c <= STEP_SPAN; c++) begin
      @(negedge clk); #1;
      if (bus.o_core_clk_en === 1'b1) extra_pulses++;
      if (bus.o_out_valid === 1'b1 && seen == 0) seen = c;
    end
    use_override = 1'b0;
    checks++;
    if (seen != STEP_SPAN || extra_pulses != 0) begin
      errors++; $display("FAIL single_latency: got valid at %0d extra_pulses %0d expected %0d and 0",
                         seen, extra_pulses, STEP_SPAN);
    end
    exp_steps++;
    checks++;
    if ({bus.o_state0, bus.o_state1, bus.o_state2} !== exp_r) begin
      errors++; $display("FAIL single_result: got %h expected %h",
                         {bus.o_state0, bus.o_state1, bus.o_state2}, exp_r);
    end
    checks++;
    if (bus.o_step_count !== sat_steps(exp_steps)) begin
      errors++; $display("FAIL single_count: got %0d expected %0d", bus.o_step_count, sat_steps(exp_steps));
    end
    @(negedge clk); #1;
    checks++;
    if ({bus.o_out_valid, bus.o_in_ready, bus.o_busy} !== 3'b010 ||
        {bus.o_state0, bus.o_state1, bus.o_state2} !== exp_r) begin
      errors++; $display("FAIL single_consume: {ov,ir,busy} got %b state %h expected 010 state %h",
                         {bus.o_out_valid, bus.o_in_ready, bus.o_busy},
                         {bus.o_state0, bus.o_state1, bus.o_state2}, exp_r);
    end
  endtask

  task automatic test_back_to_back();
    sample_t smp[3];
    int pulses[$];
    int idx, got;
    for (int i = 0; i < 3; i++) smp[i] = rand_sample();
    idx = 0; got = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && got < 3; cyc++) begin
      @(negedge clk);
      in_valid = (idx < 3);
      if (idx < 3) {u0, y0, y1} = smp[idx];
      #1;
      if (bus.o_core_clk_en === 1'b1) pulses.push_back(cyc);
      if (bus.o_out_valid === 1'b1) begin
        checks++;
        if ({bus.o_state0, bus.o_state1, bus.o_state2} !== core_fn(smp[got])) begin
          errors++; $display("FAIL b2b_result%0d: got %h expected %h", got,
                             {bus.o_state0, bus.o_state1, bus.o_state2}, core_fn(smp[got]));
        end
        got++;
      end
      if (in_valid && bus.o_in_ready === 1'b1) idx++;
    end
    in_valid = 1'b0;
    checks++;
    if (got != 3) begin
      errors++; $display("FAIL b2b_results: got %0d results expected 3", got);
    end
    checks++;
    if (pulses.size() != 3 || (pulses[1] - pulses[0]) != STEP_SPAN || (pulses[2] - pulses[1]) != STEP_SPAN) begin
      errors++; $display("FAIL b2b_spacing: got %0d pulses at %p expected 3 spaced %0d",
                         pulses.size(), pulses, STEP_SPAN);
    end
    // Two of the three steps had the next sample waiting through STEP and WAIT.
    exp_steps += 3; exp_drop += 2 * (LAT + 1);
    @(negedge clk); #1;
    checks++;
    if (bus.o_step_count !== sat_steps(exp_steps) || bus.o_drop_count !== 8'(exp_drop)) begin
      errors++; $display("FAIL b2b_counts: step %0d drop %0d expected %0d %0d",
                         bus.o_step_count, bus.o_drop_count, sat_steps(exp_steps), exp_drop);
    end
  endtask

  task automatic test_backpressure();
    sample_t a, b;
    int wait_c;
    a = rand_sample(); b = rand_sample();
    out_ready = 1'b0;
    @(negedge clk); {u0, y0, y1} = a; in_valid = 1'b1; #1;
    checks++;
    if (bus.o_in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_accept: in_ready got %b expected 1", bus.o_in_ready);
    end
    wait_c = 0;
    do begin
      @(negedge clk); in_valid = 1'b0; #1; wait_c++;
    end while (bus.o_out_valid !== 1'b1 && wait_c < 20);
    checks++;
    if (wait_c != STEP_SPAN) begin
      errors++; $display("FAIL bp_latency: got %0d expected %0d", wait_c, STEP_SPAN);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); {u0, y0, y1} = b; in_valid = 1'b1; #1;
      checks++;
      if ({bus.o_in_ready, bus.o_out_valid} !== 2'b01 ||
          {bus.o_state0, bus.o_state1, bus.o_state2} !== core_fn(a)) begin
        errors++; $display("FAIL bp_hold%0d: {ir,ov} got %b state %h expected 01 state %h", c,
                           {bus.o_in_ready, bus.o_out_valid},
                           {bus.o_state0, bus.o_state1, bus.o_state2}, core_fn(a));
      end
    end
    exp_drop += 10;
    @(negedge clk); out_ready = 1'b1; #1;
    checks++;
    if (bus.o_in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: in_ready got %b expected 1", bus.o_in_ready);
    end
    @(negedge clk); in_valid = 1'b0; #1;
    checks++;
    if (bus.o_core_clk_en !== 1'b1 || {bus.o_core_u0, bus.o_core_y0, bus.o_core_y1} !== b) begin
      errors++; $display("FAIL bp_next_step: clk_en %b core_in %h expected 1 %h", bus.o_core_clk_en,
                         {bus.o_core_u0, bus.o_core_y0, bus.o_core_y1}, b);
    end
    checks++;
    if (bus.o_drop_count !== 8'(exp_drop)) begin
      errors++; $display("FAIL bp_drop: got %0d expected %0d", bus.o_drop_count, exp_drop);
    end
    wait_c = 1;
    do begin
      @(negedge clk); #1; wait_c++;
    end while (bus.o_out_valid !== 1'b1 && wait_c < 20);
    checks++;
    if (wait_c != STEP_SPAN || {bus.o_state0, bus.o_state1, bus.o_state2} !== core_fn(b)) begin
      errors++; $display("FAIL bp_second: latency %0d state %h expected %0d %h", wait_c,
                         {bus.o_state0, bus.o_state1, bus.o_state2}, STEP_SPAN, core_fn(b));
    end
    exp_steps += 2;
    @(negedge clk); #1;
    checks++;
    if (bus.o_step_count !== sat_steps(exp_steps)) begin
      errors++; $display("FAIL bp_count: got %0d expected %0d", bus.o_step_count, sat_steps(exp_steps));
    end
  endtask

  task automatic test_clear();
    sample_t c;
    int rises;
    c = rand_sample();
    out_ready = 1'b1;
    @(negedge clk); {u0, y0, y1} = c; in_valid = 1'b1; #1;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); clear = 1'b1; #1;
    checks++;
    if (bus.o_busy !== 1'b1) begin
      errors++; $display("FAIL clear_pre_busy: got %b expected 1", bus.o_busy);
    end
    @(negedge clk); clear = 1'b0; #1;
    checks++;
    if ({bus.o_in_ready, bus.o_busy, bus.o_out_valid} !== 3'b100) begin
      errors++; $display("FAIL clear_idle: {ir,busy,ov} got %b expected 100",
                         {bus.o_in_ready, bus.o_busy, bus.o_out_valid});
    end
    rises = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (bus.o_out_valid !== 1'b0) rises++;
    end
    checks++;
    if (rises != 0) begin
      errors++; $display("FAIL clear_no_valid: got %0d valid cycles expected 0", rises);
    end
    checks++;
    if (bus.o_step_count !== sat_steps(exp_steps) || bus.o_drop_count !== 8'(exp_drop) ||
        {bus.o_core_u0, bus.o_core_y0, bus.o_core_y1} !== c) begin
      errors++; $display("FAIL clear_preserve: step %0d drop %0d core %h expected %0d %0d %h",
                         bus.o_step_count, bus.o_drop_count, {bus.o_core_u0, bus.o_core_y0, bus.o_core_y1},
                         sat_steps(exp_steps), exp_drop, c);
    end
  endtask

  task automatic test_async_reset();
    sample_t d;
    d = rand_sample();
    out_ready = 1'b1;
    @(negedge clk); {u0, y0, y1} = d; in_valid = 1'b1; #1;
    @(negedge clk); in_valid = 1'b0; #1;
    checks++;
    if (bus.o_core_clk_en !== 1'b1) begin
      errors++; $display("FAIL areset_pre: clk_en got %b expected 1", bus.o_core_clk_en);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({bus.o_core_clk_en, bus.o_out_valid, bus.o_busy, bus.o_step_count, bus.o_drop_count,
         bus.o_state0, bus.o_state1, bus.o_state2, bus.o_state3,
         bus.o_core_u0, bus.o_core_y0, bus.o_core_y1} !== '0) begin
      errors++; $display("FAIL areset_zero: got clk_en %b ov %b step %0d state %h expected all 0",
                         bus.o_core_clk_en, bus.o_out_valid, bus.o_step_count,
                         {bus.o_state0, bus.o_state1, bus.o_state2, bus.o_state3});
    end
    @(negedge clk); rst = 1'b0; #1;
    checks++;
    if ({bus.o_in_ready, bus.o_busy} !== 2'b10) begin
      errors++; $display("FAIL areset_idle: {ir,busy} got %b expected 10", {bus.o_in_ready, bus.o_busy});
    end
    exp_steps = 0; exp_drop = 0;
  endtask

  // Timeline model: a result appears STEP_SPAN cycles after its accept and is
  // offered until taken; a new sample is taken when nothing is pending or the
  // pending result leaves in the same cycle.
  task automatic test_random();
    sample_t pend_s, flight_s;
    bit offering, inflight, exp_ir, exp_ov;
    int ready_cyc, gap, accepted, consumed;
    offering = 1'b0; inflight = 1'b0; ready_cyc = 0; gap = 0; accepted = 0; consumed = 0;
    pend_s = '0; flight_s = '0;
    for (int cyc = 0; cyc < 600 && consumed < NRAND; cyc++) begin
      @(negedge clk);
      if (!offering && accepted < NRAND) begin
        if (gap > 0) gap--;
        else begin offering = 1'b1; pend_s = rand_sample(); end
      end
      in_valid = offering;
      if (offering) {u0, y0, y1} = pend_s;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_ov = inflight && (cyc >= ready_cyc);
      exp_ir = !inflight || (exp_ov && out_ready);
      checks++;
      if ({bus.o_in_ready, bus.o_out_valid} !== {exp_ir, exp_ov}) begin
        errors++; $display("FAIL rand_handshake c%0d: {ir,ov} got %b expected %b", cyc,
                           {bus.o_in_ready, bus.o_out_valid}, {exp_ir, exp_ov});
      end
      if (exp_ov && out_ready) begin
        checks++;
        if ({bus.o_state0, bus.o_state1, bus.o_state2} !== core_fn(flight_s)) begin
          errors++; $display("FAIL rand_result%0d: got %h expected %h", consumed,
                             {bus.o_state0, bus.o_state1, bus.o_state2}, core_fn(flight_s));
        end
        inflight = 1'b0; consumed++;
      end
      if (offering && !exp_ir) exp_drop++;
      if (offering && exp_ir) begin
        flight_s = pend_s; inflight = 1'b1; ready_cyc = cyc + STEP_SPAN;
        offering = 1'b0; accepted++; exp_steps++; gap = $urandom_range(0, 3);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (consumed != NRAND) begin
      errors++; $display("FAIL rand_done: got %0d results expected %0d", consumed, NRAND);
    end
    @(negedge clk); #1;
    checks++;
    if (bus.o_step_count !== sat_steps(exp_steps) || bus.o_drop_count !== 8'(exp_drop)) begin
      errors++; $display("FAIL rand_counts: step %0d drop %0d expected %0d %0d",
                         bus.o_step_count, bus.o_drop_count, sat_steps(exp_steps), exp_drop);
    end
  endtask

  task automatic test_saturation();
    int done_steps;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk); rst = 1'b0;
    exp_steps = 0; exp_drop = 0; done_steps = 0;
    for (int s = 0; s < 17; s++) begin
      @(negedge clk); {u0, y0, y1} = rand_sample(); in_valid = 1'b1;
      @(negedge clk); in_valid = 1'b0;
      repeat (STEP_SPAN - 1) @(negedge clk);
      #1;
      if (bus.o_out_valid === 1'b1) done_steps++;
      exp_steps++;
    end
    checks++;
    if (done_steps != 17 || bus.o_step_count !== sat_steps(exp_steps)) begin
      errors++; $display("FAIL sat_steps: results %0d count %0d expected 17 %0d",
                         done_steps, bus.o_step_count, sat_steps(exp_steps));
    end
    out_ready = 1'b0;
    @(negedge clk); {u0, y0, y1} = rand_sample(); in_valid = 1'b1;
    repeat (300) @(negedge clk);
    #1;
    checks++;
    if (bus.o_drop_count !== 8'd255 || bus.o_in_ready !== 1'b0) begin
      errors++; $display("FAIL sat_drop: drop %0d in_ready %b expected 255 0",
                         bus.o_drop_count, bus.o_in_ready);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: no finish by time limit, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_step();
    test_back_to_back();
    test_backpressure();
    test_clear();
    test_async_reset();
    test_random();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
